// File: rtl/ingress_requester.sv
// Store-and-forward ingress buffer for one switch input port: buffers complete
// packets and requests the output arbiter with the head packet's destination mask.
module ingress_requester #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    output logic                  port_req,
    output logic [ADDR_WIDTH-1:0] port_dst,
    input  logic                  grant,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_eop,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            wait_cnt
);

    localparam int WA = $clog2(FIFO_DEPTH);
    localparam int DA = $clog2(PKT_SLOTS);
    localparam logic [WA:0] W_ONE = {{WA{1'b0}}, 1'b1};
    localparam logic [DA:0] D_ONE = {{DA{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    logic [DATA_WIDTH:0]   r_word_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_dst_mem  [PKT_SLOTS];
    logic [WA:0]           r_wwr_ptr, r_wrd_ptr;
    logic [DA:0]           r_dwr_ptr, r_drd_ptr;
    logic [DA:0]           r_pkt_count;
    state_t                r_state, w_state_nxt;
    logic                  r_port_req;
    logic [ADDR_WIDTH-1:0] r_port_dst;
    logic [7:0]            r_drop_cnt, r_wait_cnt;

    logic                  w_word_full, w_dst_full, w_fire;
    logic                  w_pop, w_tx_valid, w_eop_pop, w_req_nxt;
    logic [DATA_WIDTH:0]   w_head_word;
    logic [ADDR_WIDTH-1:0] w_dst_head;

    // Full when pointers match except for the extra wrap bit.
    assign w_word_full = (r_wwr_ptr[WA] != r_wrd_ptr[WA]) && (r_wwr_ptr[WA-1:0] == r_wrd_ptr[WA-1:0]);
    assign w_dst_full  = (r_dwr_ptr[DA] != r_drd_ptr[DA]) && (r_dwr_ptr[DA-1:0] == r_drd_ptr[DA-1:0]);
    assign in_ready    = !w_word_full && !(in_sop && w_dst_full);
    assign w_fire      = in_valid && in_ready;
    assign w_head_word = r_word_mem[r_wrd_ptr[WA-1:0]];
    assign w_dst_head  = r_dst_mem[r_drd_ptr[DA-1:0]];
    assign w_eop_pop   = w_pop && w_head_word[DATA_WIDTH];

    // Buffer storage writes; contents are qualified by the pointers only.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_word_mem[r_wwr_ptr[WA-1:0]] <= {in_eop, in_data};
        end
        if (w_fire && in_sop) begin
            r_dst_mem[r_dwr_ptr[DA-1:0]] <= in_dst;
        end
    end

    // FIFO pointers and completed-packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wwr_ptr   <= '0;
            r_wrd_ptr   <= '0;
            r_dwr_ptr   <= '0;
            r_drd_ptr   <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_fire)            r_wwr_ptr <= r_wwr_ptr + W_ONE;
            if (w_pop)             r_wrd_ptr <= r_wrd_ptr + W_ONE;
            if (w_fire && in_sop)  r_dwr_ptr <= r_dwr_ptr + D_ONE;
            if (w_eop_pop)         r_drd_ptr <= r_drd_ptr + D_ONE;
            case ({w_fire && in_eop, w_eop_pop})
                2'b10:   r_pkt_count <= r_pkt_count + D_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - D_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // Next-state and pop/transfer decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pkt_count != '0) begin
                    w_state_nxt = (w_dst_head == '0) ? ST_DROP : ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ, ST_XFER: begin
                if (grant) begin
                    w_pop       = 1'b1;
                    w_tx_valid  = 1'b1;
                    w_state_nxt = w_head_word[DATA_WIDTH] ? ST_IDLE : ST_XFER;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_DROP: begin
                w_pop       = 1'b1;
                w_state_nxt = w_head_word[DATA_WIDTH] ? ST_IDLE : ST_DROP;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The head mask cannot change on the edge entering or staying in REQ/XFER,
    // so sampling it alongside the next state keeps port_dst fully registered.
    assign w_req_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_XFER);

    // State register and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_port_req <= 1'b0;
            r_port_dst <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_port_req <= w_req_nxt;
            r_port_dst <= w_req_nxt ? w_dst_head : {ADDR_WIDTH{1'b0}};
        end
    end

    // Saturating drop and head-wait statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            if (r_state == ST_DROP && w_eop_pop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_eop_pop) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == ST_REQ && !grant && r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign port_req = r_port_req;
    assign port_dst = r_port_dst;
    assign tx_valid = w_tx_valid;
    assign tx_data  = w_tx_valid ? w_head_word[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    assign tx_eop   = w_tx_valid && w_head_word[DATA_WIDTH];
    assign drop_cnt = r_drop_cnt;
    assign wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_ingress_requester.sv
// Directed self-checking bench for ingress_requester: framing, request timing,
// grant stalls, zero-mask drops, backpressure and asynchronous reset.
module tb_ingress_requester;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic [3:0] in_dst;
    logic       port_req;
    logic [3:0] port_dst;
    logic       grant;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_eop;
    logic [7:0] drop_cnt;
    logic [7:0] wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ingress_requester dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_dst   (in_dst),
        .port_req (port_req),
        .port_dst (port_dst),
        .grant    (grant),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_eop   (tx_eop),
        .drop_cnt (drop_cnt),
        .wait_cnt (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pkt(input int n, input logic [3:0] dst, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == n - 1);
            in_data  = base + 8'(i);
            in_dst   = dst;
            #2;
            chk("wr_ready", in_ready, 32'd1);
            next_cycle();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
        in_dst   = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] gpat;
        int         k;
        int         n_pulse;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
        in_dst   = 4'h0;
        grant    = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_port_req", port_req, 32'd0);
        chk("rst_port_dst", port_dst, 32'd0);
        chk("rst_tx_valid", tx_valid, 32'd0);
        chk("rst_tx_data",  tx_data,  32'd0);
        chk("rst_tx_eop",   tx_eop,   32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);
        chk("rst_wait_cnt", wait_cnt, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // 3-word packet, grant held high
        wr_pkt(3, 4'b0010, 8'h10);
        grant = 1'b1;
        #2;
        chk("t1_idle_req", port_req, 32'd0);
        chk("t1_idle_txv", tx_valid, 32'd0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t1_req",  port_req, 32'd1);
            chk("t1_dst",  port_dst, 32'h2);
            chk("t1_txv",  tx_valid, 32'd1);
            chk("t1_data", tx_data,  32'h10 + 32'(i));
            chk("t1_eop",  tx_eop,   (i == 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        #2;
        chk("t1_req_low", port_req, 32'd0);
        chk("t1_txv_low", tx_valid, 32'd0);
        chk("t1_data_0",  tx_data,  32'd0);
        next_cycle();
        grant = 1'b0;

        // grant withheld 5 cycles
        wr_pkt(3, 4'b0010, 8'h20);
        #2;
        chk("t2_idle_req", port_req, 32'd0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("t2_req",  port_req, 32'd1);
            chk("t2_dst",  port_dst, 32'h2);
            chk("t2_txv",  tx_valid, 32'd0);
            chk("t2_wait", wait_cnt, 32'(i));
            next_cycle();
        end
        grant = 1'b1;
        #2;
        chk("t2_wait5", wait_cnt, 32'd5);
        chk("t2_txv",   tx_valid, 32'd1);
        chk("t2_d0",    tx_data,  32'h20);
        next_cycle();
        #2;
        chk("t2_d1", tx_data, 32'h21);
        next_cycle();
        #2;
        chk("t2_d2",  tx_data, 32'h22);
        chk("t2_eop", tx_eop,  32'd1);
        next_cycle();
        grant = 1'b0;
        #2;
        chk("t2_wait_clr", wait_cnt, 32'd0);
        chk("t2_req_low",  port_req, 32'd0);
        next_cycle();

        // toggling grant over a 4-word packet
        wr_pkt(4, 4'b0100, 8'h30);
        #2;
        next_cycle();
        gpat    = 7'b1010101;
        k       = 0;
        n_pulse = 0;
        for (int i = 0; i < 7; i++) begin
            grant = gpat[i];
            #2;
            chk("t3_req", port_req, 32'd1);
            n_pulse += int'(tx_valid);
            if (grant) begin
                chk("t3_txv",  tx_valid, 32'd1);
                chk("t3_data", tx_data,  32'h30 + 32'(k));
                chk("t3_eop",  tx_eop,   (k == 3) ? 32'd1 : 32'd0);
                k++;
            end else begin
                chk("t3_idle_txv",  tx_valid, 32'd0);
                chk("t3_idle_data", tx_data,  32'd0);
            end
            next_cycle();
        end
        grant = 1'b0;
        #2;
        chk("t3_pulses",  n_pulse,  32'd4);
        chk("t3_req_low", port_req, 32'd0);
        next_cycle();

        // zero mask dropped, then multicast requested
        wr_pkt(2, 4'b0000, 8'h40);
        grant = 1'b1;
        #2;
        chk("t4_idle_req", port_req, 32'd0);
        chk("t4_drop0",    drop_cnt, 32'd0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t4_drop_req",  port_req, 32'd0);
            chk("t4_drop_txv",  tx_valid, 32'd0);
            chk("t4_drop_data", tx_data,  32'd0);
            next_cycle();
        end
        #2;
        chk("t4_drop1",   drop_cnt, 32'd1);
        chk("t4_req_low", port_req, 32'd0);
        grant = 1'b0;
        next_cycle();
        wr_pkt(2, 4'b1001, 8'h50);
        #2;
        chk("t4_b_idle", port_req, 32'd0);
        next_cycle();
        grant = 1'b1;
        #2;
        chk("t4_b_req",  port_req, 32'd1);
        chk("t4_b_dst",  port_dst, 32'h9);
        chk("t4_b_d0",   tx_data,  32'h50);
        next_cycle();
        #2;
        chk("t4_b_d1",  tx_data, 32'h51);
        chk("t4_b_eop", tx_eop,  32'd1);
        next_cycle();
        grant = 1'b0;
        #2;
        chk("t4_b_req_low", port_req, 32'd0);
        chk("t4_b_dst_low", port_dst, 32'h0);
        next_cycle();

        // fill 16 words, no grant
        wr_pkt(4, 4'b0001, 8'h60);
        wr_pkt(4, 4'b0010, 8'h70);
        wr_pkt(4, 4'b0100, 8'h80);
        wr_pkt(4, 4'b1000, 8'h90);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = 8'hEE;
        in_dst   = 4'b0001;
        #2;
        chk("t5_sop_blocked", in_ready, 32'd0);
        in_sop = 1'b0;
        #1;
        chk("t5_full",     in_ready, 32'd0);
        chk("t5_head_req", port_req, 32'd1);
        chk("t5_head_dst", port_dst, 32'h1);
        next_cycle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_dst   = 4'h0;
        grant    = 1'b1;
        #2;
        chk("t5_pop_txv",   tx_valid, 32'd1);
        chk("t5_pop_data",  tx_data,  32'h60);
        chk("t5_pop_ready", in_ready, 32'd0);
        next_cycle();
        grant = 1'b0;
        #2;
        chk("t5_ready_back", in_ready, 32'd1);
        in_sop = 1'b1;
        #1;
        chk("t5_sop_dst_full", in_ready, 32'd0);
        in_sop = 1'b0;
        next_cycle();

        // asynchronous reset mid-XFER
        grant = 1'b1;
        #2;
        chk("t6_xfer_txv",  tx_valid, 32'd1);
        chk("t6_xfer_data", tx_data,  32'h61);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req",   port_req, 32'd0);
        chk("t6_rst_dst",   port_dst, 32'h0);
        chk("t6_rst_txv",   tx_valid, 32'd0);
        chk("t6_rst_data",  tx_data,  32'd0);
        chk("t6_rst_eop",   tx_eop,   32'd0);
        chk("t6_rst_ready", in_ready, 32'd1);
        chk("t6_rst_drop",  drop_cnt, 32'd0);
        chk("t6_rst_wait",  wait_cnt, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t6_post_req", port_req, 32'd0);
            chk("t6_post_txv", tx_valid, 32'd0);
            next_cycle();
        end
        grant = 1'b0;
        wr_pkt(1, 4'b1000, 8'hA5);
        #2;
        chk("t6_new_idle", port_req, 32'd0);
        next_cycle();
        grant = 1'b1;
        #2;
        chk("t6_new_req",  port_req, 32'd1);
        chk("t6_new_dst",  port_dst, 32'h8);
        chk("t6_new_data", tx_data,  32'hA5);
        chk("t6_new_eop",  tx_eop,   32'd1);
        next_cycle();
        grant = 1'b0;
        #2;
        chk("t6_new_req_low", port_req, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ingress_requester.md
# ingress_requester

Per-input-port store-and-forward buffer and request engine that drives one requester slot (port_req bit, destination mask, grant bit) of the 4-port switch's output arbiter. It accepts packets from the port's ingress stream, holds complete packets, presents a one-hot or multicast destination mask with a request, and streams the head packet toward the crossbar one word per granted cycle. Four instances sit between the ingress ports and the arbiter/crossbar.

## Interface
- DATA_WIDTH, 8, payload word width
- ADDR_WIDTH, packet_pkg::ADDR_WIDTH (4), destination mask width, bit i = output i
- FIFO_DEPTH, 16, word buffer entries (power of 2); max packet length
- PKT_SLOTS, 4, destination-queue entries (power of 2); max buffered packets
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  ingress word valid
- in_ready  out  1  ingress may write this cycle
- in_data  in  DATA_WIDTH  ingress word
- in_sop  in  1  first word of packet
- in_eop  in  1  last word of packet
- in_dst  in  ADDR_WIDTH  destination mask, sampled only with in_sop
- port_req  out  1  request to arbiter
- port_dst  out  ADDR_WIDTH  mask of head packet, stable while port_req high
- grant  in  1  this port's arbiter grant bit (combinational from arbiter)
- tx_valid  out  1  word on tx_data transferred this cycle
- tx_data  out  DATA_WIDTH  head word; 0 when tx_valid low
- tx_eop  out  1  tx word is last of packet; 0 when tx_valid low
- drop_cnt  out  8  packets discarded for zero mask, saturating
- wait_cnt  out  8  cycles current head has waited in REQ without grant, saturating

## Operation
- Storage: word FIFO of {eop, data}, FIFO_DEPTH entries; dst FIFO of PKT_SLOTS masks; pkt_count = completed packets buffered (0..PKT_SLOTS).
- Write: fire = in_valid & in_ready. in_ready = !word_full & !(in_sop & dst_full). dst pushed on fire & in_sop; word pushed on every fire. pkt_count += 1 on fire & in_eop.
- Upstream guarantees packet length <= FIFO_DEPTH and sop/eop framing; violations are undefined.
- FSM states IDLE, REQ, XFER, DROP.
  - IDLE: if pkt_count > 0: head mask == 0 -> DROP, else -> REQ. port_req = 0.
  - REQ: port_req = 1, port_dst = dst FIFO head. If grant: pop word, tx_valid = 1; eop -> IDLE, else -> XFER. No grant: stay, wait_cnt += 1 (sat 255).
  - XFER: port_req = 1, same mask. Each cycle with grant pops one word with tx_valid = 1; cycles without grant transfer nothing, hold state. Popping eop word -> IDLE.
  - DROP: pop one word per cycle, tx_valid = 0, port_req = 0; on eop word -> IDLE, drop_cnt += 1 (sat 255).
- On eop pop (XFER/REQ/DROP): dst FIFO pops, pkt_count -= 1, wait_cnt clears.
- Simultaneous eop write and eop pop: pkt_count unchanged; both FIFOs handle concurrent push/pop including when full (pop frees entry next cycle, not same cycle).
- tx_valid = grant & (state == REQ | XFER); grant ignored in IDLE/DROP.
- Pointers wrap modulo depth; full/empty by extra MSB pointer bit.

## Timing
- Reset (async): FIFOs empty, pkt_count 0, state IDLE; in_ready 1, port_req 0, port_dst 0, tx_valid 0, tx_data 0, tx_eop 0, drop_cnt 0, wait_cnt 0.
- Reset mid-operation discards all buffered data immediately; no partial packet emerges afterward.
- eop written at edge t -> pkt_count visible cycle t+1 -> port_req high cycle t+2. With grant in cycle t+2, first word on tx_data same cycle (combinational head read).
- Packet of N words with continuous grant: N cycles REQ/XFER, then one IDLE cycle before next request.
- port_dst and port_req change only on clock edges; no combinational path from grant to port_req/port_dst.
- Combinational paths: grant -> tx_valid/tx_data/tx_eop; in_sop -> in_ready.

## Test plan
- Single 3-word packet, dst 4'b0010, grant held high: port_req rises 2 cycles after eop write, tx words 3 consecutive cycles, tx_eop on 3rd, port_req low next cycle.
- Same packet, grant low 5 cycles then high: wait_cnt reaches 5, port_dst stays 4'b0010, no tx_valid until grant; wait_cnt clears after eop.
- Grant toggling 1,0,1,0 in XFER on 4-word packet: exactly 4 tx_valid pulses in order, data intact.
- Packet with dst 4'b0000 followed by packet dst 4'b1001: first discarded, drop_cnt = 1, no port_req during drop; second requested with port_dst 4'b1001.
- Fill 16 words (4 x 4-word packets), no grant: in_ready low; 5th sop blocked; after one grant-driven pop in_ready returns next cycle.
- Reset asserted during XFER mid-packet: all outputs to reset values asynchronously; after release no residual words, pkt_count 0.
